branch_offset_narrower: RTL and testbench

// - Narrows 32-bit branch/jump distances into the 26-bit signed immediate field of KGP-RISC jump words.
// - Computes offset = target - pc and checks that it fits in signed 26 bits.
// - Packs the result with the opcode into a 32-bit instruction word.
// - Sits in the instruction loader/assembler path, ahead of instruction memory writes.
// - It is the encode-side inverse of the decode-side 26->32 sign extension: the decoder re-extends
//   the field, and the original offset is recovered only when the range check passes.
// - Two-stage valid/ready pipeline with full throughput.

---
 rtl/kgp_risc_pkg.sv | 18 +
 rtl/offset_range_check.sv | 25 ++
 rtl/branch_offset_narrower.sv | 112 +++++++++++
 tb/tb_branch_offset_narrower.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/kgp_risc_pkg.sv
// Shared KGP-RISC instruction-format constants: field widths, jump opcodes
// and the signed limits of the 26-bit jump offset field.
package kgp_risc_pkg;

  localparam int ADDR_W = 32;
  localparam int OFF_W  = 26;
  localparam int OPC_W  = 6;
  localparam int CNT_W  = 16;

  localparam logic [OPC_W-1:0] OPC_J    = 6'h02;
  localparam logic [OPC_W-1:0] OPC_JAL  = 6'h03;
  localparam logic [OPC_W-1:0] OPC_BCOND = 6'h04;

  // Largest positive and most negative values representable in the offset field
  localparam logic [OFF_W-1:0] OFFSET_MAX = {1'b0, {(OFF_W-1){1'b1}}};
  localparam logic [OFF_W-1:0] OFFSET_MIN = {1'b1, {(OFF_W-1){1'b0}}};

endpackage

// File: rtl/offset_range_check.sv
// Combinational range check of a 32-bit jump distance against the signed
// offset field. Build with OFFSET_SAT_EN to clamp out-of-range offsets.
module offset_range_check
  import kgp_risc_pkg::*;
(
  input  logic [ADDR_W-1:0] diff,
  output logic              fit,
  output logic [OFF_W-1:0]  sat_offset
);

  logic [ADDR_W-OFF_W:0] upper;

  // The offset fits when every bit above the field's sign bit matches it
  always_comb begin
    upper      = diff[ADDR_W-1:OFF_W-1];
    fit        = (upper == '0) || (upper == '1);
    sat_offset = diff[OFF_W-1:0];
`ifdef OFFSET_SAT_EN
    if (!fit) begin
      sat_offset = diff[ADDR_W-1] ? OFFSET_MIN : OFFSET_MAX;
    end
`endif
  end

endmodule

// File: rtl/branch_offset_narrower.sv
// Two-stage valid/ready pipeline packing {opcode, target-pc} into a KGP-RISC
// jump word with range-error flag and saturating error counter (OFFSET_SAT_EN).
module branch_offset_narrower
  import kgp_risc_pkg::*;
#(
  parameter int ADDR_W = kgp_risc_pkg::ADDR_W,
  parameter int OFF_W  = kgp_risc_pkg::OFF_W,
  parameter int OPC_W  = kgp_risc_pkg::OPC_W,
  parameter int CNT_W  = kgp_risc_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [ADDR_W-1:0] in_target,
  input  logic [OPC_W-1:0]  in_opcode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_instr,
  output logic              out_range_err,
  output logic [CNT_W-1:0]  err_count
);

  logic              s1_valid_q, s1_valid_d;
  logic [ADDR_W-1:0] s1_diff_q, s1_diff_d;
  logic [OPC_W-1:0]  s1_opc_q, s1_opc_d;

  logic              s2_valid_q, s2_valid_d;
  logic [ADDR_W-1:0] out_instr_q, out_instr_d;
  logic              out_err_q, out_err_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;

  logic              s2_adv;
  logic              in_fire;
  logic              out_fire;
  logic              fit;
  logic [OFF_W-1:0]  sat_offset;

  offset_range_check u_range_check (
    .diff       (s1_diff_q),
    .fit        (fit),
    .sat_offset (sat_offset)
  );

  always_comb begin
    s2_adv   = s1_valid_q && (!s2_valid_q || out_ready);
    in_ready = !s1_valid_q || s2_adv;
    in_fire  = in_valid && in_ready;
    out_fire = s2_valid_q && out_ready;
  end

  // Stage 1 captures the wrapping distance; it holds while S2 is stalled
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_diff_d  = s1_diff_q;
    s1_opc_d   = s1_opc_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_diff_d  = in_target - in_pc;
      s1_opc_d   = in_opcode;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    s2_valid_d  = s2_valid_q;
    out_instr_d = out_instr_q;
    out_err_d   = out_err_q;
    if (s2_adv) begin
      s2_valid_d  = 1'b1;
      out_instr_d = {s1_opc_q, sat_offset};
      out_err_d   = !fit;
    end else if (out_ready) begin
      s2_valid_d  = 1'b0;
    end
  end

  always_comb begin
    err_count_d = err_count_q;
    if (out_fire && out_err_q && (err_count_q != '1)) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_diff_q   <= '0;
      s1_opc_q    <= '0;
      s2_valid_q  <= 1'b0;
      out_instr_q <= '0;
      out_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_diff_q   <= s1_diff_d;
      s1_opc_q    <= s1_opc_d;
      s2_valid_q  <= s2_valid_d;
      out_instr_q <= out_instr_d;
      out_err_q   <= out_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_valid     = s2_valid_q;
  assign out_instr     = out_instr_q;
  assign out_range_err = out_err_q;
  assign err_count     = err_count_q;

endmodule

// File: tb/tb_branch_offset_narrower.sv
// Directed self-checking bench for branch_offset_narrower; expectations follow
// OFFSET_SAT_EN when the bench and RTL are built with it.
module tb_branch_offset_narrower;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_target;
  logic [5:0]  in_opcode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_range_err;
  logic [15:0] err_count;

  int total = 0;
  int bad = 0;
  int exp_errs = 0;

  // Stream vectors: opcode 0x01, entries 1 and 3 are out of range
  logic [31:0] vpc  [5] = '{32'h0000_1000, 32'h0000_0000, 32'h0000_0020, 32'h0200_0001, 32'h0000_0400};
  logic [31:0] vtgt [5] = '{32'h0000_1010, 32'h0200_0000, 32'h0000_0010, 32'h0000_0000, 32'h0000_0800};
  logic        verr [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`ifdef OFFSET_SAT_EN
  logic [31:0] vexp [5] = '{32'h0400_0010, 32'h05FF_FFFF, 32'h07FF_FFF0, 32'h0600_0000, 32'h0400_0400};
`else
  logic [31:0] vexp [5] = '{32'h0400_0010, 32'h0600_0000, 32'h07FF_FFF0, 32'h05FF_FFFF, 32'h0400_0400};
`endif

  always #5 clk = ~clk;

  branch_offset_narrower dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_pc         (in_pc),
    .in_target     (in_target),
    .in_opcode     (in_opcode),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_range_err (out_range_err),
    .err_count     (err_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_pc = '0; in_target = '0; in_opcode = '0;
    step(); step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (out_instr !== 32'h0) begin bad++; $display("FAIL reset_out_instr: got %h want 0", out_instr); end
    total++; if (out_range_err !== 1'b0) begin bad++; $display("FAIL reset_range_err: got %b want 0", out_range_err); end
    total++; if (err_count !== 16'h0) begin bad++; $display("FAIL reset_err_count: got %h want 0", err_count); end
    rst = 1'b0;
    exp_errs = 0;
  endtask

  // One isolated request with out_ready high: result visible two edges later
  task automatic send_one(input string name, input logic [31:0] pc, input logic [31:0] tgt,
                          input logic [5:0] opc, input logic [31:0] exp_instr, input logic exp_err);
    in_pc = pc; in_target = tgt; in_opcode = opc; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL %s_in_ready: got %b want 1", name, in_ready); end
    step();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL %s_early_valid: got %b want 0", name, out_valid); end
    step();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL %s_valid: got %b want 1", name, out_valid); end
    total++; if (out_instr !== exp_instr) begin bad++; $display("FAIL %s_instr: got %h want %h", name, out_instr, exp_instr); end
    total++; if (out_range_err !== exp_err) begin bad++; $display("FAIL %s_err: got %b want %b", name, out_range_err, exp_err); end
    if (exp_err) exp_errs++;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL %s_dup: got out_valid %b want 0", name, out_valid); end
  endtask

  task automatic test_basic();
    send_one("basic", 32'h0000_0100, 32'h0000_0200, 6'h02, 32'h0800_0100, 1'b0);
    send_one("backward", 32'h0000_0004, 32'h0000_0000, 6'h02, 32'h0BFF_FFFC, 1'b0);
  endtask

  task automatic test_boundaries();
    send_one("pos_edge_fit", 32'h0000_0000, 32'h01FF_FFFF, 6'h03, 32'h0DFF_FFFF, 1'b0);
    send_one("neg_edge_fit", 32'h0200_0000, 32'h0000_0000, 6'h03, 32'h0E00_0000, 1'b0);
`ifdef OFFSET_SAT_EN
    send_one("pos_overflow", 32'h0000_0000, 32'h0200_0000, 6'h03, 32'h0DFF_FFFF, 1'b1);
    send_one("neg_overflow", 32'h0200_0001, 32'h0000_0000, 6'h03, 32'h0E00_0000, 1'b1);
`else
    send_one("pos_overflow", 32'h0000_0000, 32'h0200_0000, 6'h03, 32'h0E00_0000, 1'b1);
    send_one("neg_overflow", 32'h0200_0001, 32'h0000_0000, 6'h03, 32'h0DFF_FFFF, 1'b1);
`endif
    total++;
    if (err_count !== 16'(exp_errs)) begin bad++; $display("FAIL boundary_err_count: got %h want %h", err_count, 16'(exp_errs)); end
  endtask

  // Streams the five vectors with out_ready low for the first 'stall' cycles
  task automatic run_stream(input string name, input int stall, input int exp_cycles);
    int sent = 0;
    int recv = 0;
    int cyc = 0;
    logic exp_rdy;
    logic held_v = 1'b0;
    logic [31:0] held_i = '0;
    logic held_e = 1'b0;
    while (recv < 5 && cyc < 40) begin
      in_valid = (sent < 5);
      if (sent < 5) begin
        in_pc = vpc[sent]; in_target = vtgt[sent]; in_opcode = 6'h01;
      end
      out_ready = (cyc >= stall);
      #1;
      exp_rdy = ((sent - recv) < 2) ? 1'b1 : out_ready;
      total++;
      if (in_ready !== exp_rdy) begin bad++; $display("FAIL %s_in_ready c%0d: got %b want %b", name, cyc, in_ready, exp_rdy); end
      if (held_v) begin
        total++;
        if (out_valid !== 1'b1 || out_instr !== held_i || out_range_err !== held_e) begin
          bad++; $display("FAIL %s_stall_hold c%0d: got %b/%h/%b want 1/%h/%b", name, cyc, out_valid, out_instr, out_range_err, held_i, held_e);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        total++;
        if (out_instr !== vexp[recv]) begin bad++; $display("FAIL %s_instr%0d: got %h want %h", name, recv, out_instr, vexp[recv]); end
        total++;
        if (out_range_err !== verr[recv]) begin bad++; $display("FAIL %s_err%0d: got %b want %b", name, recv, out_range_err, verr[recv]); end
        if (verr[recv]) exp_errs++;
        recv++;
      end
      held_v = (out_valid === 1'b1) && !out_ready;
      held_i = out_instr;
      held_e = out_range_err;
      if (in_valid && in_ready === 1'b1) sent++;
      step();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    total++; if (recv != 5) begin bad++; $display("FAIL %s_count: got %0d want 5", name, recv); end
    total++; if (cyc != exp_cycles) begin bad++; $display("FAIL %s_cycles: got %0d want %0d", name, cyc, exp_cycles); end
    repeat (3) begin
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL %s_extra_out: got %b want 0", name, out_valid); end
      step();
    end
    total++;
    if (err_count !== 16'(exp_errs)) begin bad++; $display("FAIL %s_err_count: got %h want %h", name, err_count, 16'(exp_errs)); end
  endtask

  task automatic test_back_to_back();
    run_stream("b2b", 0, 7);
  endtask

  task automatic test_backpressure();
    run_stream("bp", 4, 9);
  endtask

  task automatic test_reset_mid();
    in_pc = 32'h0; in_target = 32'h4000_0000; in_opcode = 6'h3F;
    in_valid = 1'b1; out_ready = 1'b0;
    step(); step();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rstmid_loaded: got %b want 1", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rstmid_full: got %b want 0", in_ready); end
    rst = 1'b1;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
    total++; if (err_count !== 16'h0) begin bad++; $display("FAIL rstmid_err_count: got %h want 0", err_count); end
    rst = 1'b0; out_ready = 1'b1; exp_errs = 0;
    repeat (4) begin
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_stale: got %b want 0", out_valid); end
    end
    total++; if (err_count !== 16'h0) begin bad++; $display("FAIL rstmid_err_after: got %h want 0", err_count); end
  endtask

  task automatic test_counter();
    in_pc = 32'h0; in_target = 32'h4000_0000; in_opcode = 6'h3F;
    in_valid = 1'b1; out_ready = 1'b1;
    repeat (32'h100) step();
    total++; if (err_count !== 16'h00FE) begin bad++; $display("FAIL counter_mid: got %h want 00fe", err_count); end
    repeat (32'h10002 - 32'h100) step();
    in_valid = 1'b0;
    repeat (3) step();
    total++; if (err_count !== 16'hFFFF) begin bad++; $display("FAIL counter_sat: got %h want ffff", err_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_counter();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
